// File: rtl/dac_seq_ctrl_if.sv
// Update handshake and parallel DAC bus shared by the sequencer and its neighbours.
interface dac_seq_ctrl_if #(
   parameter int AW = 2,
   parameter int DW = 8
);
   logic          upd_vld;
   logic [AW-1:0] upd_ch;
   logic [DW-1:0] upd_code;
   logic          upd_rdy;
   logic          dac_wr;
   logic [AW-1:0] dac_a;
   logic [DW-1:0] dac_din;

   // Pattern/switch logic side: issues updates, observes the DAC bus.
   modport master (
      output upd_vld, upd_ch, upd_code,
      input  upd_rdy, dac_wr, dac_a, dac_din
   );

   // Sequencer side: accepts updates, drives the DAC bus.
   modport slave (
      input  upd_vld, upd_ch, upd_code,
      output upd_rdy, dac_wr, dac_a, dac_din
   );
endinterface

// File: rtl/dac_seq_ctrl.sv
// Multi-channel DAC sequencer: keeps a shadow code per channel, powers rails up and down
// in order, and writes only changed channels to the DAC with programmable strobe timing.
module dac_seq_ctrl #(
   parameter int NCH      = 4,
   parameter int AW       = 2,
   parameter int DW       = 8,
   parameter int NRAIL    = 4,
   parameter int RAIL_DLY = 1000,
   parameter int WR_SETUP = 2,
   parameter int WR_PULSE = 4,
   parameter int WR_HOLD  = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   dac_seq_ctrl_if.slave    bus,
   output logic [NRAIL-1:0] rail_en,
   output logic             ready,
   output logic             busy
);
   localparam int TOT = WR_SETUP + WR_PULSE + WR_HOLD;
   localparam int PW  = $clog2(TOT + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(TOT - 1);
   localparam logic [PW-1:0] PH_LO    = PW'(WR_SETUP);
   localparam logic [PW-1:0] PH_HI    = PW'(WR_SETUP + WR_PULSE);
   localparam logic [15:0]   DLY_LAST = 16'(RAIL_DLY - 1);
   localparam logic [AW-1:0] CH_LAST  = AW'(NCH - 1);

   typedef enum logic [2:0] {S_OFF, S_RAIL_UP, S_INIT_WR, S_IDLE, S_WRITE, S_RAIL_DN} state_t;

   state_t           state_reg, state_next;
   logic [NRAIL-1:0] rail_reg, rail_next;
   logic [15:0]      cnt_reg, cnt_next;
   logic [NCH-1:0]   dirty_reg, dirty_next;
   logic [DW-1:0]    shadow_reg [NCH];
   logic [AW-1:0]    rr_reg, rr_next;
   logic [AW-1:0]    ch_reg, ch_next;
   logic [PW-1:0]    ph_reg, ph_next;
   logic             stop_reg, stop_next;
   logic             init_reg, init_next;
   logic             ready_reg, ready_next;
   logic             busy_reg, busy_next;
   logic             wr_reg, wr_next;
   logic [AW-1:0]    a_reg, a_next;
   logic [DW-1:0]    din_reg, din_next;
   logic             rdy_reg, rdy_next;

   logic             acc_ok;
   logic             load;
   logic             set_all;
   logic [AW-1:0]    ch_inc;
   logic [AW-1:0]    pick_ptr;
   logic [AW-1:0]    pick_ch;
   logic [AW-1:0]    pick_tmp;
   logic             pick_ok;
   int               pick_idx;

   // Out-of-range channels complete the handshake but touch nothing.
   assign acc_ok = bus.upd_vld & rdy_reg & (32'(bus.upd_ch) < NCH);
   assign ch_inc = (ch_reg == CH_LAST) ? '0 : ch_reg + AW'(1);

   // Round-robin pick: first dirty channel at or after the pointer, wrapping.
   // While a write finishes, the pointer it is about to leave behind is used so
   // back-to-back writes need no extra cycle.
   always_comb begin
      pick_ptr = (state_reg == S_WRITE) ? ch_inc : rr_reg;
      pick_ok  = 1'b0;
      pick_ch  = '0;
      pick_idx = 0;
      pick_tmp = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         pick_idx = (int'(pick_ptr) + i) % NCH;
         pick_tmp = AW'(pick_idx);
         if (dirty_reg[pick_tmp]) begin
            pick_ok = 1'b1;
            pick_ch = pick_tmp;
         end
      end
   end

   // Next-state, rail sequencing, write timing and dirty bookkeeping.
   always_comb begin
      state_next = state_reg;
      rail_next  = rail_reg;
      cnt_next   = cnt_reg;
      rr_next    = rr_reg;
      ch_next    = ch_reg;
      ph_next    = ph_reg;
      stop_next  = stop_reg;
      init_next  = init_reg;
      ready_next = ready_reg;
      a_next     = a_reg;
      din_next   = din_reg;
      load       = 1'b0;
      set_all    = 1'b0;
      if (!run) ready_next = 1'b0;
      case (state_reg)
         S_OFF: begin
            if (run) begin
               state_next = S_RAIL_UP;
               rail_next  = NRAIL'(1);
               cnt_next   = '0;
            end
         end
         S_RAIL_UP: begin
            if (!run) begin
               state_next = S_RAIL_DN;
               rail_next  = rail_reg >> 1;
               cnt_next   = '0;
            end else if (cnt_reg == DLY_LAST) begin
               cnt_next = '0;
               if (&rail_reg) begin
                  state_next = S_INIT_WR;
                  set_all    = 1'b1;
                  init_next  = 1'b1;
               end else begin
                  rail_next = (rail_reg << 1) | NRAIL'(1);
               end
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         S_INIT_WR, S_IDLE: begin
            if (!run) begin
               state_next = S_RAIL_DN;
               rail_next  = rail_reg >> 1;
               cnt_next   = '0;
            end else if (pick_ok) begin
               load = 1'b1;
            end else if (state_reg == S_INIT_WR) begin
               state_next = S_IDLE;
               ready_next = 1'b1;
               init_next  = 1'b0;
            end
         end
         S_WRITE: begin
            // A falling run is remembered so the strobe in flight is never cut short.
            if (!run) stop_next = 1'b1;
            if (ph_reg == PH_LAST) begin
               rr_next = ch_inc;
               if (stop_reg || !run) begin
                  state_next = S_RAIL_DN;
                  rail_next  = rail_reg >> 1;
                  cnt_next   = '0;
                  stop_next  = 1'b0;
               end else if (pick_ok) begin
                  load = 1'b1;
               end else begin
                  state_next = init_reg ? S_INIT_WR : S_IDLE;
               end
            end else begin
               ph_next = ph_reg + PW'(1);
            end
         end
         S_RAIL_DN: begin
            if (cnt_reg == DLY_LAST) begin
               cnt_next = '0;
               if (rail_reg == '0) state_next = S_OFF;
               else                rail_next  = rail_reg >> 1;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         default: state_next = S_OFF;
      endcase
      if (load) begin
         state_next = S_WRITE;
         ch_next    = pick_ch;
         ph_next    = '0;
         a_next     = pick_ch;
         din_next   = shadow_reg[pick_ch];
      end
      // Order matters: a same-cycle accept re-dirties the channel being cleared.
      dirty_next = dirty_reg;
      if (set_all) dirty_next = '1;
      if (load)    dirty_next[pick_ch] = 1'b0;
      if (acc_ok)  dirty_next[bus.upd_ch] = 1'b1;
      busy_next = (state_next == S_WRITE);
      wr_next   = ~((state_next == S_WRITE) && (ph_next >= PH_LO) && (ph_next < PH_HI));
      rdy_next  = (state_next != S_RAIL_DN);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_OFF;
         rail_reg  <= '0;
         cnt_reg   <= '0;
         dirty_reg <= '0;
         rr_reg    <= '0;
         ch_reg    <= '0;
         ph_reg    <= '0;
         stop_reg  <= 1'b0;
         init_reg  <= 1'b0;
         ready_reg <= 1'b0;
         busy_reg  <= 1'b0;
         wr_reg    <= 1'b1;
         a_reg     <= '0;
         din_reg   <= '0;
         rdy_reg   <= 1'b0;
         for (int i = 0; i < NCH; i++) shadow_reg[i] <= '0;
      end else begin
         state_reg <= state_next;
         rail_reg  <= rail_next;
         cnt_reg   <= cnt_next;
         dirty_reg <= dirty_next;
         rr_reg    <= rr_next;
         ch_reg    <= ch_next;
         ph_reg    <= ph_next;
         stop_reg  <= stop_next;
         init_reg  <= init_next;
         ready_reg <= ready_next;
         busy_reg  <= busy_next;
         wr_reg    <= wr_next;
         a_reg     <= a_next;
         din_reg   <= din_next;
         rdy_reg   <= rdy_next;
         if (acc_ok) shadow_reg[bus.upd_ch] <= bus.upd_code;
      end
   end

   assign rail_en     = rail_reg;
   assign ready       = ready_reg;
   assign busy        = busy_reg;
   assign bus.upd_rdy = rdy_reg;
   assign bus.dac_wr  = wr_reg;
   assign bus.dac_a   = a_reg;
   assign bus.dac_din = din_reg;
endmodule
